// File: rtl/lane_light_demux_pkg.sv
// Shared types for the two-lane light controller: light encodings, FSM states
// and the phase counter width.
package lane_light_demux_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    RED    = 2'b10
  } light_t;

  typedef enum logic [1:0] {
    A_GREEN  = 2'b00,
    A_YELLOW = 2'b01,
    B_GREEN  = 2'b10,
    B_YELLOW = 2'b11
  } lane_state_t;

endpackage

// File: rtl/lane_light_demux_tick_counter.sv
// Phase counter: clears on request, counts enable pulses, saturates at all-ones.
module tick_counter
  import lane_light_demux_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (en && (cnt != {W{1'b1}}))
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/lane_light_demux.sv
// Two-lane traffic light Moore FSM; lights and grant decode from the state register only.
module lane_light_demux
  import lane_light_demux_pkg::*;
#(
  parameter int YELLOW_TICKS    = 5,
  parameter int MIN_GREEN_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ta,
  input  logic       tb,
  output logic [1:0] la,
  output logic [1:0] lb,
  output logic       grant
);

  localparam logic [CNT_W-1:0] MIN_G    = CNT_W'(MIN_GREEN_TICKS);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_TICKS - 1);

  lane_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt;
  light_t           la_l, lb_l;

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= A_GREEN;
    else
      state_q <= state_d;
  end

  // All transitions are gated by tick, so sensors only matter at tick edges.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case (state_q)
        A_GREEN:  if (!ta && cnt >= MIN_G) state_d = A_YELLOW;
        A_YELLOW: if (cnt == YEL_LAST)     state_d = B_GREEN;
        B_GREEN:  if (!tb && cnt >= MIN_G) state_d = B_YELLOW;
        B_YELLOW: if (cnt == YEL_LAST)     state_d = A_GREEN;
        default:  state_d = A_GREEN;
      endcase
    end
  end

  tick_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state_d != state_q),
    .en    (tick),
    .cnt   (cnt)
  );

  always_comb begin
    la_l  = RED;
    lb_l  = RED;
    grant = 1'b0;
    unique case (state_q)
      A_GREEN:  la_l = GREEN;
      A_YELLOW: la_l = YELLOW;
      B_GREEN:  begin lb_l = GREEN;  grant = 1'b1; end
      B_YELLOW: begin lb_l = YELLOW; grant = 1'b1; end
      default:  ;
    endcase
  end

  assign la = la_l;
  assign lb = lb_l;

endmodule

// File: doc/lane_light_demux.md
LANE_LIGHT_DEMUX -- requirements
Module: lane_light_demux

Interface
REQ-001 Parameter YELLOW_TICKS, default 5, number of tick pulses spent in each yellow phase (range 1..15).
REQ-002 Parameter MIN_GREEN_TICKS, default 2, minimum tick pulses a green phase lasts before it may end (range 0..15).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1, rising-edge clock for all state.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port tick, input, 1, single-cycle timing enable from an external prescaler; all timing counts tick pulses only.
REQ-007 Port ta, input, 1, traffic sensor for lane A; 1 means traffic is present.
REQ-008 Port tb, input, 1, traffic sensor for lane B; 1 means traffic is present.
REQ-009 Port la, output, 2, lane A light: 00 green, 01 yellow, 10 red; 11 never driven.
REQ-010 Port lb, output, 2, lane B light, same encoding as la.
REQ-011 Port grant, output, 1, right-of-way selector: 0 means lane A, 1 means lane B; downstream 2:1 selection consumes it directly.

Function
REQ-012 The block SHALL implement four Moore states: A_GREEN, A_YELLOW, B_GREEN, B_YELLOW.
REQ-013 State outputs SHALL be: A_GREEN la=00 lb=10 grant=0; A_YELLOW la=01 lb=10 grant=0; B_GREEN la=10 lb=00 grant=1; B_YELLOW la=10 lb=01 grant=1.
REQ-014 Outputs SHALL decode from the registered state only, so they change in the same cycle the state register updates, with no combinational path from ta, tb or tick.
REQ-015 A 4-bit phase counter SHALL clear on every state change and increment, saturating at 15, on each cycle where tick=1 and the state does not change.
REQ-016 From A_GREEN, the state SHALL move to A_YELLOW on a clock edge with tick=1, ta=0 and counter>=MIN_GREEN_TICKS; otherwise it holds.
REQ-017 From A_YELLOW, the state SHALL move to B_GREEN on the tick edge where counter==YELLOW_TICKS-1; ta and tb are ignored.
REQ-018 B_GREEN to B_YELLOW and B_YELLOW to A_GREEN SHALL mirror REQ-016 and REQ-017, with tb in place of ta.
REQ-019 No transition SHALL occur on a cycle with tick=0, whatever the sensor values.
REQ-020 With ta=tb=1 held, A_GREEN SHALL persist indefinitely; there is no starvation timeout.
REQ-021 With tick held at 1 continuously, counting SHALL occur every cycle, and a yellow phase SHALL last exactly YELLOW_TICKS cycles.
REQ-022 Sensor changes SHALL be sampled only at tick edges; glitches between ticks have no effect.
REQ-023 No cycle SHALL show both la and lb in a non-red state.

Reset
REQ-024 When reset=1 at a clock edge, the block SHALL enter A_GREEN with counter=0, giving la=00, lb=10, grant=0 in the following cycle.
REQ-025 Reset SHALL take priority over tick, including when both are asserted in the same cycle.
REQ-026 Reset asserted mid-yellow or during B_GREEN SHALL abort the phase immediately, with no partial yellow afterwards.
REQ-027 No other reset values or initial blocks SHALL be relied upon.

Structure
REQ-028 A shared package SHALL hold:
- light_t enum (GREEN=2'b00, YELLOW=2'b01, RED=2'b10);
- lane_state_t enum for the four states;
- the 4-bit counter width constant.
REQ-029 The phase counter with clear, enable and saturation SHALL be the one sub-module, named tick_counter; the FSM and output decode stay in lane_light_demux.

Verification
REQ-030 Reset with tick=1 and ta=tb=1 -> la=00, lb=10, grant=0 in the cycle after reset, held for 20 ticks.
REQ-031 From A_GREEN, drop ta=0 after 3 ticks with default parameters -> A_YELLOW on the next tick, then B_GREEN after exactly 5 ticks, with grant switching 0 to 1 at B_GREEN entry.
REQ-032 ta=0 from reset -> no A_YELLOW before 2 ticks have elapsed (MIN_GREEN_TICKS), then A_YELLOW on the 3rd tick.
REQ-033 With tick held high and ta=tb=0 -> continuous cycle of 3 green, 5 yellow, 3 green, 5 yellow cycles, and REQ-023 holds throughout.
REQ-034 Assert reset during the 3rd B_YELLOW tick -> next cycle la=00, lb=10, grant=0, and counter restarts from 0.
REQ-035 Toggle ta with tick=0 for 50 cycles -> state and outputs unchanged.
